coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end stage that feeds the vending-machine FSM its per-cycle coin code (00 none, 01 = 5₹, 10 = 10₹). It takes two raw coin-slot sensor lines (5₹ and 10₹), synchronises and debounces them, and turns each debounced rising edge into one coin event. Events queue in a small FIFO and are released one per cycle while the downstream FSM asserts accept_en. Coins that cannot be accepted, because the FIFO is full or both sensors fire together, are flagged for physical return.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a sensor must differ from its stable value before the stable value flips (>=1)
FIFO_DEPTH, 4, coin-event queue depth (power of 2, >=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sense5  input  1  raw 5₹ slot sensor, asynchronous, high while coin present
sense10  input  1  raw 10₹ slot sensor, asynchronous, high while coin present
accept_en  input  1  downstream may consume a coin this cycle
coin  output  2  coin code to FSM: 00 none, 01 5₹, 10 10₹; 11 never driven
reject  output  1  one-cycle pulse: coin dropped, return to customer
overflow  output  1  sticky: at least one coin rejected because FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset is synchronous, active-high, on posedge clk. All state clears: sync flops, stable values, debounce counters, FIFO pointers and count, coin=00, reject=0, overflow=0, fifo_count=0. Reset mid-operation discards all queued coins.
- Synchroniser: two flops per sensor. s5/s10 denote the second-flop outputs.
- Debounce, per channel:
  - stable reg and counter.
  - When s == stable, counter clears to 0.
  - Otherwise counter increments. On the DEBOUNCE_CYCLES-th consecutive differing edge, stable flips and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles are ignored.
- Event: ev = stable & ~stable_d, where stable_d is registered. Only rising edges generate events; falling edges produce nothing.
- Sensor held high across reset release: stable restarts at 0, so the held sensor yields exactly one event after debounce. This is intentional.
- Push, evaluated each cycle on ev5/ev10:
  - Exactly one event and (not full, or pop this cycle): push 01 (ev5) or 10 (ev10).
  - Exactly one event, full, and no pop: drop the event, reject=1 next cycle, overflow set.
  - Both events in the same cycle: push nothing, reject=1 next cycle. overflow is not affected.
- Pop: at each posedge, if accept_en and FIFO non-empty, coin <= head and read pointer advances; otherwise coin <= 00.
  - coin is registered and holds each code for exactly one cycle.
  - Back-to-back pops give consecutive non-zero codes.
- Simultaneous push and pop: both occur and fifo_count is unchanged. This includes push into a full FIFO with concurrent pop, which is accepted.
- No bypass: a pushed entry is poppable no earlier than the edge after the push.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. fifo_count ranges 0..FIFO_DEPTH and is updated registered, same edge as push/pop.
- Latency: raw sensor first sampled high at edge 0, held, FIFO empty, accept_en=1. Events occur in this order:
  - s high after edge 1.
  - stable flips at edge D+1, where D=DEBOUNCE_CYCLES.
  - push at edge D+2.
  - coin valid for the cycle following edge D+3; for D=4 that is 7 edges.
- reject is a registered single-cycle pulse. The downstream FSM (S0/S5/S10) is unaffected by it.
- overflow clears only on reset.

Test Plan:
- D=4: sense5 high 20 cycles from edge 0, accept_en=1 -> coin=01 exactly one cycle after edge 7, 00 otherwise; fifo_count 0→1→0.
- sense10 pulse of 3 synchronised cycles -> no event; coin stays 00, fifo_count 0.
- accept_en=0, five separate debounced 5₹ coins -> fifo_count reaches 4; fifth coin gives reject pulse and overflow=1. Then accept_en=1 -> four consecutive cycles coin=01, count→0.
- sense5 and sense10 rise on the same edge, held -> single reject pulse, no push, overflow=0.
- FIFO full with accept_en=1 and a new 10₹ event in the same cycle -> pop and push both occur, count stays 4, no reject; order preserved (10 emerges last).
- Three coins queued, reset asserted one cycle -> coin=00, fifo_count=0, overflow=0 next cycle. Nothing emitted after reset unless a sensor is still high.

Source files
------------

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : coin_acceptor
//  Description : Coin-slot front end. Synchronises and debounces the 5 and
//                10 sensor lines, turns each debounced rising edge into a coin
//                event, queues events in a small FIFO and releases one coin
//                code per cycle while the downstream FSM asserts accept_en.
//                Coins that cannot be queued are flagged for return.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,  // consecutive differing cycles to flip
  parameter int FIFO_DEPTH      = 4   // power of 2, >= 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sense5,
  input  logic                          sense10,
  input  logic                          accept_en,
  output logic [1:0]                    coin,
  output logic                          reject,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // Counter wide enough to hold DEBOUNCE_CYCLES-1; pointer width log2(depth).
  localparam int c_CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_PW         = $clog2(FIFO_DEPTH);
  localparam int c_DB_LAST_I  = DEBOUNCE_CYCLES - 1;
  localparam int c_FULL_I     = FIFO_DEPTH;

  localparam logic [c_CW-1:0] c_DB_LAST = c_DB_LAST_I[c_CW-1:0];
  localparam logic [c_PW:0]   c_FULL    = c_FULL_I[c_PW:0];

  localparam logic [1:0] c_COIN_NONE = 2'b00;
  localparam logic [1:0] c_COIN_5    = 2'b01;
  localparam logic [1:0] c_COIN_10   = 2'b10;

  // Channel 0 is the 5 sensor, channel 1 the 10 sensor.
  logic [1:0] w_raw;
  logic [1:0] w_ev;

  assign w_raw = {sense10, sense5};

  // --------------------------------------------------------------------------
  // Per-channel synchroniser, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < 2; g++) begin : g_chan
      logic            r_meta;
      logic            r_sync;
      logic            r_stable;
      logic            r_stable_d;
      logic [c_CW-1:0] r_cnt;

      // Two-flop synchroniser, then stable value flips only after the
      // synchronised input has disagreed for DEBOUNCE_CYCLES edges in a row.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_meta     <= 1'b0;
          r_sync     <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_meta     <= w_raw[g];
          r_sync     <= r_meta;
          r_stable_d <= r_stable;
          if (r_sync == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // Only a debounced low-to-high transition counts as a coin.
      assign w_ev[g] = r_stable & ~r_stable_d;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Coin-event FIFO
  // --------------------------------------------------------------------------
  logic [1:0]      r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW:0]   r_count;
  logic [1:0]      r_coin;
  logic            r_reject;
  logic            r_overflow;

  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_one_ev;
  logic       w_both_ev;
  logic       w_push;
  logic       w_drop_full;
  logic [1:0] w_push_code;

  // Push/pop decisions. A pop frees a slot in the same cycle, so a full FIFO
  // with a concurrent pop still accepts the new coin.
  always_comb begin
    w_full      = (r_count == c_FULL);
    w_empty     = (r_count == '0);
    w_pop       = accept_en & ~w_empty;
    w_one_ev    = w_ev[0] ^ w_ev[1];
    w_both_ev   = w_ev[0] & w_ev[1];
    w_push      = w_one_ev & (~w_full | w_pop);
    w_drop_full = w_one_ev & w_full & ~w_pop;
    w_push_code = w_ev[1] ? c_COIN_10 : c_COIN_5;
  end

  // Queue storage; contents are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_code;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered outputs: coin code for one cycle, reject pulse, sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coin     <= c_COIN_NONE;
      r_reject   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_coin     <= w_pop ? r_mem[r_rd_ptr] : c_COIN_NONE;
      r_reject   <= w_both_ev | w_drop_full;
      r_overflow <= r_overflow | w_drop_full;
    end
  end

  assign coin       = r_coin;
  assign reject     = r_reject;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_acceptor
//  Description : Directed self-checking bench for coin_acceptor
//                (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_coin_acceptor;

  logic       clk;
  logic       reset;
  logic       sense5;
  logic       sense10;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks;
  int failures;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sense5     (sense5),
    .sense10    (sense10),
    .accept_en  (accept_en),
    .coin       (coin),
    .reject     (reject),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One clean 5 coin: 8 cycles high, then 8 cycles low so the debouncer
  // settles back to 0 before the next coin.
  task automatic drop_coin5();
    sense5 = 1'b1;
    idle(8);
    sense5 = 1'b0;
    idle(8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++;
    if (coin !== 2'b00 || reject !== 1'b0 || overflow !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got coin=%b reject=%b overflow=%b count=%0d want 00/0/0/0",
               coin, reject, overflow, fifo_count);
    end
    reset = 1'b0;
    step();
  endtask

  // Held 5 sensor: push at edge 6, coin=01 only after edge 7.
  task automatic test_latency();
    logic [1:0] exp_coin;
    logic [2:0] exp_cnt;
    accept_en = 1'b1;
    sense5    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      exp_coin = (k == 7) ? 2'b01 : 2'b00;
      exp_cnt  = (k == 6) ? 3'd1 : 3'd0;
      checks++;
      if (coin !== exp_coin) begin
        failures++;
        $display("FAIL latency_coin edge=%0d got=%b want=%b", k, coin, exp_coin);
      end
      checks++;
      if (fifo_count !== exp_cnt) begin
        failures++;
        $display("FAIL latency_count edge=%0d got=%0d want=%0d", k, fifo_count, exp_cnt);
      end
    end
    sense5 = 1'b0;
    // Falling edge must not generate anything.
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (coin !== 2'b00 || reject !== 1'b0) begin
        failures++;
        $display("FAIL falling_edge cyc=%0d got coin=%b reject=%b want 00/0", k, coin, reject);
      end
    end
  endtask

  // 3-cycle pulse is shorter than the debounce window.
  task automatic test_glitch();
    accept_en = 1'b1;
    sense10   = 1'b1;
    idle(3);
    sense10 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if (coin !== 2'b00 || fifo_count !== 3'd0 || reject !== 1'b0) begin
        failures++;
        $display("FAIL glitch cyc=%0d got coin=%b count=%0d reject=%b want 00/0/0",
                 k, coin, fifo_count, reject);
      end
    end
  endtask

  // Fill to 4, fifth coin rejected with overflow, then drain 4 coins.
  task automatic test_overflow();
    int rej_pulses;
    accept_en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      drop_coin5();
      checks++;
      if (fifo_count !== 3'(c) || reject !== 1'b0 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL fill coin=%0d got count=%0d reject=%b overflow=%b want %0d/0/0",
                 c, fifo_count, reject, overflow, c);
      end
    end
    rej_pulses = 0;
    sense5 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (reject === 1'b1) rej_pulses++;
    end
    sense5 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (reject === 1'b1) rej_pulses++;
    end
    checks++;
    if (rej_pulses != 1) begin
      failures++;
      $display("FAIL overflow_reject got pulses=%0d want 1", rej_pulses);
    end
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL overflow_flag got overflow=%b count=%0d want 1/4", overflow, fifo_count);
    end
    accept_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (coin !== ((k < 4) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL drain cyc=%0d got coin=%b want %b", k, coin, (k < 4) ? 2'b01 : 2'b00);
      end
    end
    checks++;
    if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL drain_end got count=%0d overflow=%b want 0/1", fifo_count, overflow);
    end
  endtask

  // Full FIFO, 10 event arrives in the same cycle as a pop: both happen.
  task automatic test_full_concurrent();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    accept_en = 1'b0;
    for (int c = 0; c < 4; c++) drop_coin5();
    checks++;
    if (fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL full_setup got count=%0d want 4", fifo_count);
    end
    sense10 = 1'b1;
    idle(6);            // edges 0..5: stable flips at edge 5, event this cycle
    accept_en = 1'b1;   // pop coincides with the push at edge 6
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (coin !== exp_seq[k] || reject !== 1'b0) begin
        failures++;
        $display("FAIL concurrent cyc=%0d got coin=%b reject=%b want %b/0",
                 k, coin, reject, exp_seq[k]);
      end
      if (k == 0) begin
        checks++;
        if (fifo_count !== 3'd4) begin
          failures++;
          $display("FAIL concurrent_count got=%0d want 4", fifo_count);
        end
      end
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL concurrent_end got count=%0d want 0", fifo_count);
    end
    sense10 = 1'b0;
    idle(10);
  endtask

  // Three coins queued (overflow still set), one-cycle reset clears all.
  task automatic test_reset_mid();
    accept_en = 1'b0;
    for (int c = 0; c < 3; c++) drop_coin5();
    checks++;
    if (fifo_count !== 3'd3 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL midreset_setup got count=%0d overflow=%b want 3/1", fifo_count, overflow);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (coin !== 2'b00 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midreset got coin=%b count=%0d overflow=%b want 00/0/0",
               coin, fifo_count, overflow);
    end
    accept_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (coin !== 2'b00 || fifo_count !== 3'd0) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got coin=%b count=%0d want 00/0", k, coin, fifo_count);
      end
    end
  endtask

  // Both sensors rise together: one reject pulse, nothing queued.
  task automatic test_both();
    int rej_pulses;
    int bad_count;
    accept_en  = 1'b0;
    rej_pulses = 0;
    bad_count  = 0;
    sense5  = 1'b1;
    sense10 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (reject === 1'b1) rej_pulses++;
      if (fifo_count !== 3'd0) bad_count++;
    end
    sense5  = 1'b0;
    sense10 = 1'b0;
    idle(8);
    checks++;
    if (rej_pulses != 1) begin
      failures++;
      $display("FAIL both_reject got pulses=%0d want 1", rej_pulses);
    end
    checks++;
    if (bad_count != 0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL both_nopush got nonzero_count_cycles=%0d overflow=%b want 0/0",
               bad_count, overflow);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    sense5    = 1'b0;
    sense10   = 1'b0;
    accept_en = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_overflow();
    test_full_concurrent();
    test_reset_mid();
    test_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
